// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte producers. One requester is
// granted per frame, and its byte is latched at grant time. The arbiter then
// holds tx_start until the transmitter reports busy and waits for busy to fall.
// It pulses a one-cycle ack to the served requester and inserts an idle gap
// before the next grant. If busy never rises within START_TIMEOUT cycles, the
// frame is aborted: the requester is still acked and timeout_err is set until
// the next reset.
//
// Arbitration:
//   default               round robin; the search starts at the requester
//                         after the one most recently served
//   UART_ARB_PRIO_EN      fixed priority; the lowest pending index wins and
//                         the round-robin pointer stays at 0
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req          per-requester level request, held until ack
//   req_data     packed bytes, requester i at [i*DATA_W +: DATA_W]
//   ack          one-cycle pulse to the served requester
//   tx_data      latched byte to transmitter
//   tx_start     start strobe to transmitter
//   tx_busy      transmitter busy status
//   grant_id     index of requester currently / last served
//   active       high whenever the FSM is not idle
//   timeout_err  sticky start-timeout flag
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = 1000,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int IDX_W   = ID_W + 1;
    localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    // The gap state always lasts at least one cycle, so a zero gap leaves
    // on the first edge.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     ptr_reg, ptr_next;
    logic [ID_W-1:0]     grant_id_reg, grant_id_next;
    logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
    logic                tx_start_reg, tx_start_next;
    logic [NUM_REQ-1:0]  ack_reg, ack_next;
    logic                timeout_err_reg, timeout_err_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic [DATA_W-1:0]   slot_data [NUM_REQ];
    logic [2*NUM_REQ-2:0] req_dbl;
    logic [NUM_REQ-1:0]  req_rot;
    logic                found;
    logic [ID_W-1:0]     offset;
    logic [IDX_W-1:0]    pick_sum;
    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     ptr_adv;

    // The request vector is doubled so that a rotation starting at ptr_reg
    // becomes a plain index; the search window never crosses bit 2*NUM_REQ-2.
    assign req_dbl = {req[NUM_REQ-2:0], req};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign slot_data[gi] = req_data[gi*DATA_W +: DATA_W];
            assign req_rot[gi]   = req_dbl[{1'b0, ptr_reg} + IDX_W'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated vector = first pending requester at or
    // after the pointer.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found  = 1'b1;
                offset = ID_W'(i);
            end
        end
    end

    assign pick_sum = {1'b0, ptr_reg} + {1'b0, offset};
    assign pick     = (pick_sum >= IDX_W'(NUM_REQ)) ? ID_W'(pick_sum - IDX_W'(NUM_REQ))
                                                    : ID_W'(pick_sum);

`ifdef UART_ARB_PRIO_EN
    // The pointer stays at 0, so the rotation is the identity and the
    // lowest pending index always wins.
    assign ptr_adv = '0;
`else
    assign ptr_adv = (grant_id_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            grant_id_reg    <= '0;
            tx_data_reg     <= '0;
            tx_start_reg    <= 1'b0;
            ack_reg         <= '0;
            timeout_err_reg <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            grant_id_reg    <= grant_id_next;
            tx_data_reg     <= tx_data_next;
            tx_start_reg    <= tx_start_next;
            ack_reg         <= ack_next;
            timeout_err_reg <= timeout_err_next;
            cnt_reg         <= cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        grant_id_next    = grant_id_reg;
        tx_data_next     = tx_data_reg;
        tx_start_next    = tx_start_reg;
        ack_next         = '0;
        timeout_err_next = timeout_err_reg;
        cnt_next         = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    grant_id_next = pick;
                    tx_data_next  = slot_data[pick];
                    tx_start_next = 1'b1;
                    cnt_next      = '0;
                    state_next    = START;
                end
            end
            START: begin
                // Busy wins over timeout when both happen on the same cycle.
                if (tx_busy) begin
                    tx_start_next = 1'b0;
                    state_next    = SEND;
                end else if (cnt_reg == START_LAST) begin
                    tx_start_next          = 1'b0;
                    timeout_err_next       = 1'b1;
                    ack_next[grant_id_reg] = 1'b1;
                    ptr_next               = ptr_adv;
                    cnt_next               = '0;
                    state_next             = GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    ack_next[grant_id_reg] = 1'b1;
                    ptr_next               = ptr_adv;
                    cnt_next               = '0;
                    state_next             = GAP;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ack         = ack_reg;
    assign tx_data     = tx_data_reg;
    assign tx_start    = tx_start_reg;
    assign grant_id    = grant_id_reg;
    assign active      = (state_reg != IDLE);
    assign timeout_err = timeout_err_reg;

endmodule
